// File: rtl/rgb_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pkg
// Shared definitions for the RGB fader:
//   - state_e          : fader FSM states (IDLE, FADE)
//   - RED/GREEN/BLUE   : bit positions of each channel inside the 3-bit
//                        colour command code
//   - MAX_CH_W         : widest channel the helper function supports
//   - colour_to_target : expands a 3-bit colour code into a packed
//                        {red, green, blue} target, each channel either
//                        all-ones or zero at the requested channel width
// ---------------------------------------------------------------------------
package rgb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_e;

  localparam int unsigned RED   = 32'd2;
  localparam int unsigned GREEN = 32'd1;
  localparam int unsigned BLUE  = 32'd0;

  localparam int unsigned MAX_CH_W = 32'd16;

  // The result is always 3*MAX_CH_W wide; callers narrow it to 3*ch_w with
  // a size cast. Channels are packed red-high, blue-low at ch_w spacing.
  function automatic logic [3*MAX_CH_W-1:0] colour_to_target(
    input logic [2:0]  colour,
    input int unsigned ch_w
  );
    logic [3*MAX_CH_W-1:0] full_s;
    logic [3*MAX_CH_W-1:0] res_s;
    full_s = (48'd1 << ch_w) - 48'd1;
    res_s  = 48'd0;
    if (colour[RED]) begin
      res_s = res_s | (full_s << (32'd2 * ch_w));
    end else begin
      res_s = res_s;
    end
    if (colour[GREEN]) begin
      res_s = res_s | (full_s << ch_w);
    end else begin
      res_s = res_s;
    end
    if (colour[BLUE]) begin
      res_s = res_s | full_s;
    end else begin
      res_s = res_s;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/rgb_channel_ramp.sv
// ---------------------------------------------------------------------------
// rgb_channel_ramp
// Combinational saturating stepper for one colour channel. On a tick the
// channel moves toward its target by min(STEP, |target - current|), so it
// never overshoots and never wraps. Without a tick, or when the channel
// already sits on its target, the current value passes straight through.
//
// Parameters
//   CH_W : channel width in bits
//   STEP : increment applied per tick
// Ports
//   cur_i  [CH_W-1:0] : present channel value
//   tgt_i  [CH_W-1:0] : value the channel is heading for
//   tick_i            : advance one step this cycle
//   nxt_o  [CH_W-1:0] : next channel value
// ---------------------------------------------------------------------------
module rgb_channel_ramp #(
  parameter int unsigned CH_W = 8,
  parameter int unsigned STEP = 1
) (
  input  logic [CH_W-1:0] cur_i,
  input  logic [CH_W-1:0] tgt_i,
  input  logic            tick_i,
  output logic [CH_W-1:0] nxt_o
);

  // One guard bit keeps cur+STEP from wrapping before the clamp compares it.
  localparam logic [CH_W:0] STEP_X = (CH_W+1)'(STEP);

  logic [CH_W:0] cur_x_s;
  logic [CH_W:0] tgt_x_s;
  logic [CH_W:0] diff_x_s;
  logic [CH_W:0] nxt_x_s;

  assign cur_x_s = {1'b0, cur_i};
  assign tgt_x_s = {1'b0, tgt_i};

  // Step toward the target, clamping the final step onto it.
  always_comb begin
    diff_x_s = '0;
    nxt_x_s  = cur_x_s;
    if (!tick_i) begin
      nxt_x_s = cur_x_s;
    end else if (cur_x_s < tgt_x_s) begin
      diff_x_s = tgt_x_s - cur_x_s;
      nxt_x_s  = (diff_x_s > STEP_X) ? (cur_x_s + STEP_X) : tgt_x_s;
    end else if (cur_x_s > tgt_x_s) begin
      diff_x_s = cur_x_s - tgt_x_s;
      nxt_x_s  = (diff_x_s > STEP_X) ? (cur_x_s - STEP_X) : tgt_x_s;
    end else begin
      nxt_x_s = cur_x_s;
    end
  end

  // The clamp keeps the guard bit at zero, so dropping it loses nothing.
  assign nxt_o = CH_W'(nxt_x_s);

endmodule

// File: rtl/rgb_fader.sv
// ---------------------------------------------------------------------------
// rgb_fader
// Accepts a 3-bit colour command and ramps a registered RGB output toward
// the matching full-scale/zero target, one STEP per prescaled tick.
//
// Parameters
//   CH_W     : bits per channel (2..16)
//   STEP     : per-tick increment (1..2^CH_W-1)
//   PRESCALE : enabled cycles per ramp tick (1..65535)
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : advances prescaler and ramp; low freezes both
//   colour[2:0]: command colour (bit2 red, bit1 green, bit0 blue)
//   cmd_valid  : command offered
//   cmd_ready  : high in IDLE, command can be taken
//   rgb        : {red, green, blue}, each CH_W bits, registered
//   busy       : high in FADE
//   done       : one-cycle pulse after a fade reaches its target
//   abort      : (only with RGB_FADER_ABORT_EN) stop the fade, hold rgb,
//                return to IDLE without done
//
// Build option: define RGB_FADER_ABORT_EN to add the abort input.
// ---------------------------------------------------------------------------
module rgb_fader
  import rgb_pkg::*;
#(
  parameter int unsigned CH_W     = 8,
  parameter int unsigned STEP     = 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [2:0]        colour,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [3*CH_W-1:0] rgb,
  output logic              busy,
  output logic              done
`ifdef RGB_FADER_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int unsigned RGB_W = 3 * CH_W;
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  state_e             state_q;
  state_e             state_d;
  logic [RGB_W-1:0]   target_q;
  logic [RGB_W-1:0]   target_d;
  logic [RGB_W-1:0]   rgb_q;
  logic [RGB_W-1:0]   rgb_d;
  logic [15:0]        presc_q;
  logic [15:0]        presc_d;
  logic               done_q;
  logic               done_d;

  logic               tick_s;
  logic               at_tgt_s;
  logic               abort_s;
  logic [RGB_W-1:0]   step_s;

`ifdef RGB_FADER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign tick_s   = enable && (presc_q == PRESC_LAST);
  assign at_tgt_s = (rgb_q == target_q);

  // Three identical steppers, one per channel; blue sits in the low slice.
  for (genvar g = 0; g < 3; g++) begin : g_ch
    rgb_channel_ramp #(
      .CH_W (CH_W),
      .STEP (STEP)
    ) u_ramp (
      .cur_i  (rgb_q[g*CH_W +: CH_W]),
      .tgt_i  (target_q[g*CH_W +: CH_W]),
      .tick_i (tick_s),
      .nxt_o  (step_s[g*CH_W +: CH_W])
    );
  end

  // Next-state and datapath control for the IDLE/FADE machine.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    rgb_d    = rgb_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d = RGB_W'(colour_to_target(colour, CH_W));
          presc_d  = 16'd0;
          state_d  = FADE;
        end else begin
          state_d = IDLE;
        end
      end
      FADE: begin
        // Completion is tested against the registered rgb, ahead of any
        // tick, so a no-change command finishes one edge after acceptance.
        if (abort_s) begin
          state_d = IDLE;
        end else if (at_tgt_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (enable) begin
          rgb_d   = step_s;
          presc_d = tick_s ? 16'd0 : (presc_q + 16'd1);
        end else begin
          state_d = FADE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, target, colour, prescaler and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      rgb_q    <= '0;
      presc_q  <= 16'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      rgb_q    <= rgb_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  assign rgb       = rgb_q;
  assign done      = done_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == FADE);

endmodule

// File: tb/tb_rgb_fader.sv
`timescale 1ns/1ps
// Two faders (PRESCALE 1 and 4, STEP 16, CH_W 8) share one stimulus stream
// and are compared every cycle against an arithmetic model of the fade.
module tb_rgb_fader;

  localparam int CH_W = 8;
  localparam int STEP = 16;
  localparam int FULL = 255;
  localparam int PA   = 1;
  localparam int PB   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  colour;
  logic        cmd_valid;
  logic        abort;
  logic        rdy [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [23:0] rgb [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per instance, whether a fade is running, the three
  // channel targets and values (0=red,1=green,2=blue), enabled-cycle count
  // since last tick, and the done flag seen after the latest edge.
  int prs    [2] = '{PA, PB};
  int m_busy [2];
  int m_done [2];
  int m_cnt  [2];
  int m_tgt  [2][3];
  int m_cur  [2][3];

  always #5 clk = ~clk;

  rgb_fader #(.CH_W(CH_W), .STEP(STEP), .PRESCALE(PA)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .colour(colour),
    .cmd_valid(cmd_valid), .cmd_ready(rdy[0]), .rgb(rgb[0]),
    .busy(bsy[0]), .done(dn[0])
`ifdef RGB_FADER_ABORT_EN
    , .abort(abort)
`endif
  );

  rgb_fader #(.CH_W(CH_W), .STEP(STEP), .PRESCALE(PB)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .colour(colour),
    .cmd_valid(cmd_valid), .cmd_ready(rdy[1]), .rgb(rgb[1]),
    .busy(bsy[1]), .done(dn[1])
`ifdef RGB_FADER_ABORT_EN
    , .abort(abort)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] m_rgb(input int i);
    return 24'((m_cur[i][0] << 16) | (m_cur[i][1] << 8) | m_cur[i][2]);
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0;
      m_done[i] = 0;
      m_cnt[i]  = 0;
      for (int c = 0; c < 3; c++) begin
        m_tgt[i][c] = 0;
        m_cur[i][c] = 0;
      end
    end
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    int ab;
    ab = 0;
`ifdef RGB_FADER_ABORT_EN
    ab = (abort === 1'b1) ? 1 : 0;
`endif
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (m_busy[i] == 0) begin
        if (cmd_valid) begin
          for (int c = 0; c < 3; c++) m_tgt[i][c] = colour[2-c] ? FULL : 0;
          m_busy[i] = 1;
          m_cnt[i]  = 0;
        end
      end else if (ab != 0) begin
        m_busy[i] = 0;
      end else if (m_rgb(i) == 24'((m_tgt[i][0] << 16) | (m_tgt[i][1] << 8) | m_tgt[i][2])) begin
        m_busy[i] = 0;
        m_done[i] = 1;
      end else if (enable) begin
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == prs[i]) begin
          m_cnt[i] = 0;
          for (int c = 0; c < 3; c++) begin
            int d;
            d = m_tgt[i][c] - m_cur[i][c];
            if (d > 0) m_cur[i][c] += min2(STEP, d);
            else if (d < 0) m_cur[i][c] -= min2(STEP, -d);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rgb%0d", i),   32'(rgb[i]), 32'(m_rgb(i)));
      check_eq($sformatf("busy%0d", i),  32'(bsy[i]), 32'(m_busy[i]));
      check_eq($sformatf("ready%0d", i), 32'(rdy[i]), 32'(m_busy[i] == 0));
      check_eq($sformatf("done%0d", i),  32'(dn[i]),  32'(m_done[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Pulse reset between edges and confirm it takes effect without a clock.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_async_rgb", 32'(rgb[0]), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int dcount;
    rst_n     = 1'b0;
    enable    = 1'b1;
    colour    = 3'b000;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fade to white; PRESCALE=1 instance steps 0x10 per cycle.
    colour = 3'b111; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    check_eq("white_first", 32'(rgb[0]), 32'h101010);
    dcount = 0;
    for (int n = 0; n < 80; n++) begin
      cyc();
      if (dn[0]) dcount++;
    end
    check_eq("white_final_a", 32'(rgb[0]), 32'hFFFFFF);
    check_eq("white_final_b", 32'(rgb[1]), 32'hFFFFFF);
    check_eq("white_done_cnt", 32'(dcount), 32'd1);
    check_eq("white_ready", 32'(rdy[0]), 32'd1);

    // Fade to red: green/blue fall, final step clamps at zero.
    colour = 3'b100; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    check_eq("red_first", 32'(rgb[0]), 32'hFFEFEF);
    for (int n = 0; n < 80; n++) cyc();
    check_eq("red_final_a", 32'(rgb[0]), 32'hFF0000);
    check_eq("red_final_b", 32'(rgb[1]), 32'hFF0000);

    // Same colour again: one busy cycle, then done.
    colour = 3'b100; cmd_valid = 1'b1;
    cyc();
    check_eq("same_busy", 32'(bsy[0]), 32'd1);
    cmd_valid = 1'b0;
    cyc();
    check_eq("same_done", 32'(dn[0]), 32'd1);
    check_eq("same_idle", 32'(bsy[0]), 32'd0);
    check_eq("same_rgb", 32'(rgb[0]), 32'hFF0000);
    cyc();
    check_eq("same_done_off", 32'(dn[0]), 32'd0);

    // Enable toggling every 3 cycles with cmd_valid held through FADE.
    colour = 3'b011; cmd_valid = 1'b1;
    for (int n = 0; n < 150; n++) begin
      enable = ((n / 3) % 2 == 0);
      cyc();
    end
    cmd_valid = 1'b0; enable = 1'b1;
    for (int n = 0; n < 80; n++) cyc();

    // Reset mid-fade: rgb drops at once, no done afterwards.
    apply_reset();
    colour = 3'b111; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    for (int n = 0; n < 4; n++) cyc();
    apply_reset();
    check_eq("rst_idle", 32'(rdy[0]), 32'd1);
    for (int n = 0; n < 4; n++) cyc();

`ifdef RGB_FADER_ABORT_EN
    // Abort at 0x505050 on the way to white.
    colour = 3'b111; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    for (int n = 0; n < 5; n++) cyc();
    check_eq("abort_pre", 32'(rgb[0]), 32'h505050);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check_eq("abort_rgb", 32'(rgb[0]), 32'h505050);
    check_eq("abort_idle", 32'(bsy[0]), 32'd0);
    check_eq("abort_nodone", 32'(dn[0]), 32'd0);
    cyc();
    check_eq("abort_nodone2", 32'(dn[0]), 32'd0);
`endif

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end
      enable    = ($urandom_range(0, 3) != 0);
      cmd_valid = ($urandom_range(0, 1) == 1);
      colour    = 3'($urandom_range(0, 7));
`ifdef RGB_FADER_ABORT_EN
      abort     = ($urandom_range(0, 29) == 0);
`endif
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_fader.md
RGB_FADER -- requirements
Module: rgb_fader

Interface
REQ-001 Parameter CH_W, default 8: bits per colour channel; legal range 2..16.
REQ-002 Parameter STEP, default 1: per-tick channel increment; legal range 1..2^CH_W-1.
REQ-003 Parameter PRESCALE, default 1: enabled clock cycles per ramp tick; legal range 1..65535.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port enable  input  1  high = prescaler and ramp advance; low = both frozen.
REQ-007 Port colour  input  3  command colour code: bit2 red, bit1 green, bit0 blue.
REQ-008 Port cmd_valid  input  1  command offered.
REQ-009 Port cmd_ready  output  1  block can accept a command.
REQ-010 Port rgb  output  3*CH_W  registered colour: red [3*CH_W-1:2*CH_W], green [2*CH_W-1:CH_W], blue [CH_W-1:0].
REQ-011 Port busy  output  1  high while in FADE.
REQ-012 Port done  output  1  one-cycle pulse when a fade completes.

Function
REQ-013 Target mapping: each colour bit set gives its channel 2^CH_W-1; each bit clear gives 0.
REQ-014 FSM has two states: IDLE and FADE; cmd_ready = (state==IDLE); busy = (state==FADE).
REQ-015 Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready; the target is latched and the FSM enters FADE on that edge.
REQ-016 cmd_valid while in FADE is ignored, not queued; the source holds it until cmd_ready.
REQ-017 Prescaler: counts enabled cycles in FADE from 0 to PRESCALE-1; tick = enable && count==PRESCALE-1; cleared on command acceptance.
REQ-018 On each tick, every channel moves toward its target by min(STEP, |target-current|); there is no overshoot and no wrap-around.
REQ-019 Channel arithmetic uses CH_W+1 bits internally; channels already at target stay unchanged.
REQ-020 In FADE, on any edge where registered rgb equals target, the FSM returns to IDLE and done is high for the following cycle only; this check is independent of tick and enable.
REQ-021 A command whose target equals the current rgb completes in one cycle: accepted at edge k, IDLE with done high after edge k+1.
REQ-022 With enable low in FADE, rgb and the prescaler hold; busy stays high.
REQ-023 In IDLE, rgb holds its last value.

Reset
REQ-024 Asserting rst_n low immediately forces the state to IDLE, rgb to 0, target to 0, prescaler to 0, and done to 0, including during a fade.
REQ-025 After reset release: cmd_ready=1, busy=0; the first command is accepted on the first qualifying edge.

Configuration
REQ-026 Macro RGB_FADER_ABORT_EN, when defined, adds a 1-bit input abort: abort high in FADE stops the fade at the next edge, holds rgb at its current value, returns to IDLE, and does not assert done.
REQ-027 Without RGB_FADER_ABORT_EN, the abort port and its logic are absent and a fade always runs to completion.

Structure
REQ-028 Package rgb_pkg holds the state enum (IDLE, FADE), the colour-bit index constants (RED=2, GREEN=1, BLUE=0), and a colour-to-target function parameterised by CH_W.
REQ-029 Sub-module rgb_channel_ramp implements one channel's saturating stepper (current, target, tick, STEP); rgb_fader instantiates it three times.

Verification (CH_W=8, STEP=16, PRESCALE=1, enable=1 unless stated)
REQ-030 Reset, then command colour=3'b111 -> rgb rises 0x000000, 0x101010, … 0xF0F0F0, 0xFFFFFF on 16 consecutive ticks; done pulses once; cmd_ready returns to 1.
REQ-031 From 0xFFFFFF, command 3'b100 -> red holds 0xFF; green and blue fall 0xEF, 0xDF, … 0x0F, 0x00 over 16 ticks; final rgb is 0xFF0000.
REQ-032 Command equal to the current colour -> busy high for exactly 1 cycle, done pulses, rgb unchanged.
REQ-033 PRESCALE=4 with enable toggling every 3 cycles -> rgb changes only after 4 enabled cycles; it freezes while enable is low; cmd_valid during FADE is ignored.
REQ-034 rst_n pulsed low mid-fade -> rgb is 0 immediately (asynchronously), state is IDLE, and no done pulse occurs.
REQ-035 With RGB_FADER_ABORT_EN: abort at rgb=0x505050 toward white -> rgb holds 0x505050, the block returns to IDLE, and done stays 0.
